// File: rtl/ysyx_24110015_axi_sram_slave.sv
// rtl/ysyx_24110015_axi_sram_slave.sv - AXI4-Lite responder in front of a word-addressed SRAM, one transaction at a time
// Optional build macro: YSYX_24110015_SRAM_RAND_DELAY_EN (per-transaction latency 1..16 cycles from an 8-bit LFSR)
module ysyx_24110015_axi_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH_LG2 = 16,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
  parameter int                LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int         CNT_W       = 16;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    W_COLLECT,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] wa_q;
  logic [31:0]       wd_q;
  logic [3:0]        ws_q;
  logic              aw_got;
  logic              w_got;

  logic [31:0]       mem [2**DEPTH_LG2];

  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              rd_req;
  logic              wr_req;
  logic              wait_done;
  logic              enter_rd;
  logic              enter_wr;
  logic              mem_we;
  logic [CNT_W-1:0]  lat_ld;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic              rd_ok;
  logic              wr_ok;
  logic [DEPTH_LG2-1:0] rd_idx;
  logic [DEPTH_LG2-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

`ifdef YSYX_24110015_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR (taps 8,6,5,4); its low nibble picks the next transaction's extra delay
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'h01;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_ld = {{(CNT_W-4){1'b0}}, lfsr[3:0]};
`else
  assign lat_ld = CNT_W'(LATENCY - 1);
`endif

  // Channel readies: read has priority in IDLE, only the missing write half is open while collecting
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          arready = 1'b1;
          awready = !arvalid;
          wready  = !arvalid;
        end
        W_COLLECT: begin
          awready = !aw_got;
          wready  = !w_got;
        end
        default: ;
      endcase
    end
  end

  // Handshakes, effective request fields and the range decode done on the full-width offset
  always_comb begin
    ar_hs   = arvalid && arready;
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;

    rd_addr = (state == IDLE) ? araddr : ra_q;
    wr_addr = aw_hs ? awaddr : wa_q;
    wr_data = w_hs ? wdata : wd_q;
    wr_strb = w_hs ? wstrb : ws_q;

    rd_off  = rd_addr - MEM_BASE;
    wr_off  = wr_addr - MEM_BASE;
    rd_ok   = (rd_addr >= MEM_BASE) && ((rd_off >> (DEPTH_LG2 + 2)) == '0);
    wr_ok   = (wr_addr >= MEM_BASE) && ((wr_off >> (DEPTH_LG2 + 2)) == '0);
    rd_idx  = rd_off[DEPTH_LG2+1:2];
    wr_idx  = wr_off[DEPTH_LG2+1:2];

    rd_req  = (state == IDLE) && ar_hs;
    wr_req  = ((state == IDLE) && !ar_hs && aw_hs && w_hs) ||
              ((state == W_COLLECT) && (aw_got || aw_hs) && (w_got || w_hs));

    wait_done = (cnt == CNT_W'(1));
    enter_rd  = (rd_req && (lat_ld == '0)) || ((state == RD_WAIT) && wait_done);
    enter_wr  = (wr_req && (lat_ld == '0)) || ((state == WR_WAIT) && wait_done);
    mem_we    = enter_wr && wr_ok && !rst;
  end

  // SRAM array: byte-lane write on the edge the write response goes valid; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Transaction FSM with registered response channels
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ra_q   <= '0;
      wa_q   <= '0;
      wd_q   <= '0;
      ws_q   <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else begin
      if (enter_rd) begin
        rvalid <= 1'b1;
        rdata  <= rd_ok ? mem[rd_idx] : 32'h0;
        rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (enter_wr) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end

      case (state)
        IDLE: begin
          if (ar_hs) begin
            ra_q  <= araddr;
            cnt   <= lat_ld;
            state <= (lat_ld == '0) ? RD_RESP : RD_WAIT;
          end else if (aw_hs || w_hs) begin
            if (aw_hs) wa_q <= awaddr;
            if (w_hs) begin
              wd_q <= wdata;
              ws_q <= wstrb;
            end
            if (wr_req) begin
              cnt   <= lat_ld;
              state <= (lat_ld == '0) ? WR_RESP : WR_WAIT;
            end else begin
              aw_got <= aw_hs;
              w_got  <= w_hs;
              state  <= W_COLLECT;
            end
          end
        end

        W_COLLECT: begin
          if (aw_hs) wa_q <= awaddr;
          if (w_hs) begin
            wd_q <= wdata;
            ws_q <= wstrb;
          end
          if (wr_req) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            cnt    <= lat_ld;
            state  <= (lat_ld == '0) ? WR_RESP : WR_WAIT;
          end
        end

        RD_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (wait_done) state <= RD_RESP;
        end

        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        WR_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (wait_done) state <= WR_RESP;
        end

        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_sram_slave.sv
// tb/tb_ysyx_24110015_axi_sram_slave.sv - self-checking bench for the AXI4-Lite SRAM responder
module tb_ysyx_24110015_axi_sram_slave;

  localparam int          TB_LAT = 3;
  localparam int          LIM    = 100;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  logic [31:0] d1_araddr, d1_awaddr, d1_wdata, d1_rdata;
  logic        d1_arvalid, d1_arready, d1_rvalid, d1_rready;
  logic        d1_awvalid, d1_awready, d1_wvalid, d1_wready, d1_bvalid, d1_bready;
  logic [3:0]  d1_wstrb;
  logic [1:0]  d1_rresp, d1_bresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24110015_axi_sram_slave #(.LATENCY(TB_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_24110015_axi_sram_slave #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .araddr(d1_araddr), .arvalid(d1_arvalid), .arready(d1_arready),
    .rdata(d1_rdata), .rresp(d1_rresp), .rvalid(d1_rvalid), .rready(d1_rready),
    .awaddr(d1_awaddr), .awvalid(d1_awvalid), .awready(d1_awready),
    .wdata(d1_wdata), .wstrb(d1_wstrb), .wvalid(d1_wvalid), .wready(d1_wready),
    .bresp(d1_bresp), .bvalid(d1_bvalid), .bready(d1_bready)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [int unsigned];
  logic [31:0] q_rd[$];
  logic [1:0]  q_rr[$];
  logic [1:0]  q_br[$];
  int          cyc = 0, racc = 0, wacc = 0;
  logic        got_aw = 0, got_w = 0, prev_rst = 0, pr_rhold = 0, pr_bhold = 0;
  logic [31:0] m_aw, m_wd;
  logic [3:0]  m_ws;

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h0004_0000);
  endfunction

  function automatic logic lat_ok(input int l);
`ifdef YSYX_24110015_SRAM_RAND_DELAY_EN
    return (l >= 1) && (l <= 16);
`else
    return l == TB_LAT;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_arready", arready, 0);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      q_rd.delete(); q_rr.delete(); q_br.delete();
      got_aw = 0; got_w = 0; pr_rhold = 0; pr_bhold = 0;
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_bvalid", bvalid, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_arready", arready, 1);
      end
      if (got_aw ^ got_w) chk("collect_arready", arready, 0);
      if (rvalid) begin
        if (q_rd.size() == 0) fail_now("stray_rvalid");
        else begin
          if (!pr_rhold && !lat_ok(cyc - racc)) chk("rd_latency", cyc - racc, TB_LAT);
          else if (!pr_rhold) chk("rd_latency", 1, 1'b1);
          chk("mdl_rdata", rdata, q_rd[0]);
          chk("mdl_rresp", rresp, q_rr[0]);
          if (rready) begin void'(q_rd.pop_front()); void'(q_rr.pop_front()); end
        end
      end else if (pr_rhold) fail_now("rvalid_dropped");
      if (bvalid) begin
        if (q_br.size() == 0) fail_now("stray_bvalid");
        else begin
          if (!pr_bhold && !lat_ok(cyc - wacc)) chk("wr_latency", cyc - wacc, TB_LAT);
          chk("mdl_bresp", bresp, q_br[0]);
          if (bready) void'(q_br.pop_front());
        end
      end else if (pr_bhold) fail_now("bvalid_dropped");
      pr_rhold = rvalid && !rready;
      pr_bhold = bvalid && !bready;
      if (arvalid && arready) begin
        q_rd.push_back(in_rng(araddr) ? (mdl.exists((araddr - BASE) / 4) ? mdl[(araddr - BASE) / 4] : 32'h0) : 32'h0);
        q_rr.push_back(in_rng(araddr) ? 2'b00 : 2'b10);
        racc = cyc;
      end
      if (awvalid && awready) begin got_aw = 1; m_aw = awaddr; end
      if (wvalid && wready) begin got_w = 1; m_wd = wdata; m_ws = wstrb; end
      if (got_aw && got_w) begin
        if (in_rng(m_aw)) begin
          logic [31:0] w;
          w = mdl.exists((m_aw - BASE) / 4) ? mdl[(m_aw - BASE) / 4] : 32'h0;
          for (int b = 0; b < 4; b++) if (m_ws[b]) w[8*b +: 8] = m_wd[8*b +: 8];
          mdl[(m_aw - BASE) / 4] = w;
        end
        q_br.push_back(in_rng(m_aw) ? 2'b00 : 2'b10);
        wacc = cyc; got_aw = 0; got_w = 0;
      end
      prev_rst = 0;
    end
    cyc++;
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] r, output int lat);
    int t;
    araddr = a; arvalid = 1;
    t = 0; @(negedge clk);
    while (!arready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("arready_timeout");
    @(posedge clk); #1 arvalid = 0;
    lat = 1; @(negedge clk);
    while (!rvalid && lat < LIM) begin @(negedge clk); lat++; end
    if (lat >= LIM) fail_now("rvalid_timeout");
    d = rdata; r = rresp;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 rready = 1;
    @(posedge clk); #1 rready = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int hold, output logic [1:0] br);
    int t;
    wdata = d; wstrb = s; wvalid = 1;
    if (lead == 0) begin awaddr = a; awvalid = 1; end
    t = 0; @(negedge clk);
    while (!wready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("wready_timeout");
    @(posedge clk); #1 wvalid = 0; awvalid = 0;
    if (lead > 0) begin
      repeat (lead) @(posedge clk);
      #1 awaddr = a; awvalid = 1;
      t = 0; @(negedge clk);
      while (!awready && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) fail_now("awready_timeout");
      @(posedge clk); #1 awvalid = 0;
    end
    t = 0; @(negedge clk);
    while (!bvalid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("bvalid_timeout");
    br = bresp;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1 bready = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d, a;
    logic [1:0]  r;
    int          lat, t;

    rst = 1;
    {araddr, awaddr, wdata} = '0; wstrb = 0;
    {arvalid, rready, awvalid, wvalid, bready} = '0;
    {d1_araddr, d1_awaddr, d1_wdata} = '0; d1_wstrb = 0;
    {d1_arvalid, d1_rready, d1_awvalid, d1_wvalid, d1_bready} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset in the middle of a read wait
    @(posedge clk); #1 araddr = BASE; arvalid = 1;
    @(posedge clk); #1 arvalid = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_arready", arready, 1);
    for (int i = 0; i < 6; i++) begin @(negedge clk); chk("rst_no_stray", rvalid | bvalid, 0); end
    @(posedge clk); #1;

    // full write then read back
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
    chk("wr_bresp", r, 2'b00);
    do_read(32'h8000_0010, 0, d, r, lat);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_rresp", r, 2'b00);
`ifndef YSYX_24110015_SRAM_RAND_DELAY_EN
    chk("rd_lat3", lat, TB_LAT);
`endif

    // byte-lane strobes
    do_write(32'h8000_0030, 32'h1122_3344, 4'hF, 0, 1, r);
    do_write(32'h8000_0030, 32'hAABB_CCDD, 4'b0101, 0, 0, r);
    do_read(32'h8000_0032, 0, d, r, lat);
    chk("strb_data", d, 32'h11BB_33DD);

    // W three cycles ahead of AW
    do_write(32'h8000_0004, 32'h0000_0005, 4'hF, 3, 0, r);
    chk("split_bresp", r, 2'b00);
    do_read(32'h8000_0004, 0, d, r, lat);
    chk("split_data", d, 32'h0000_0005);

    // below-base error read with back-pressure
    do_read(32'h7FFF_FFFC, 5, d, r, lat);
    chk("err_rdata", d, 32'h0);
    chk("err_rresp", r, 2'b10);

    // range edges and aliasing guard
    do_write(32'h8003_FFFC, 32'h0BAD_F00D, 4'hF, 0, 0, r);
    chk("top_bresp", r, 2'b00);
    do_read(32'h8003_FFFC, 0, d, r, lat);
    chk("top_data", d, 32'h0BAD_F00D);
    do_write(32'h8000_0000, 32'h0102_0304, 4'hF, 0, 0, r);
    do_write(32'h8004_0000, 32'hFFFF_FFFF, 4'hF, 1, 0, r);
    chk("over_bresp", r, 2'b10);
    do_read(32'h8004_0000, 0, d, r, lat);
    chk("over_rresp", r, 2'b10);
    chk("over_rdata", d, 32'h0);
    do_write(32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, r);
    chk("strb0_bresp", r, 2'b00);
    do_read(32'h8000_0000, 0, d, r, lat);
    chk("no_alias_data", d, 32'h0102_0304);

    // AR and AW/W together: read goes first, write stalls then completes
    araddr = 32'h8000_0010; arvalid = 1;
    awaddr = 32'h8000_0010; awvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    chk("conc_arready", arready, 1);
    chk("conc_awready", awready, 0);
    @(posedge clk); #1 arvalid = 0;
    t = 0; @(negedge clk);
    while (!rvalid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("conc_rvalid_timeout");
    chk("conc_read_first", rdata, 32'hDEAD_BEEF);
    chk("conc_no_bvalid", bvalid, 0);
    @(posedge clk); #1 rready = 1;
    @(posedge clk); #1 rready = 0;
    t = 0; @(negedge clk);
    while (!(awready && wready) && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("conc_aw_timeout");
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    t = 0; @(negedge clk);
    while (!bvalid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) fail_now("conc_bvalid_timeout");
    chk("conc_bresp", bresp, 2'b00);
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1 bready = 0;
    do_read(32'h8000_0010, 0, d, r, lat);
    chk("conc_after", d, 32'h1234_5678);

    // random traffic checked by the model
    for (int i = 0; i < 16; i++) do_write(32'h8000_0100 + 4 * i, $urandom, 4'hF, 0, 0, r);
    for (int i = 0; i < 300; i++) begin
      a = 32'h8000_0100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? 32'h7FFF_FF00 + $urandom_range(0, 255)
                                                             : 32'h8004_0000 + $urandom_range(0, 255);
      if ($urandom_range(0, 1)) do_read(a, $urandom_range(0, 3), d, r, lat);
      else do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3), r);
    end

    // LATENCY=1 instance: responses the cycle after acceptance
    d1_awaddr = 32'h8000_0020; d1_awvalid = 1; d1_wdata = 32'hCAFE_F00D; d1_wstrb = 4'hF; d1_wvalid = 1;
    @(negedge clk);
    chk("d1_awready", d1_awready, 1);
    chk("d1_wready", d1_wready, 1);
    @(posedge clk); #1 d1_awvalid = 0; d1_wvalid = 0;
    @(negedge clk);
    chk("d1_bvalid_lat1", d1_bvalid, 1);
    chk("d1_bresp", d1_bresp, 2'b00);
    @(posedge clk); #1 d1_bready = 1;
    @(posedge clk); #1 d1_bready = 0;
    @(negedge clk);
    chk("d1_bvalid_clr", d1_bvalid, 0);
    @(posedge clk); #1 d1_araddr = 32'h8000_0020; d1_arvalid = 1;
    @(negedge clk);
    chk("d1_arready", d1_arready, 1);
    @(posedge clk); #1 d1_arvalid = 0;
    @(negedge clk);
    chk("d1_rvalid_lat1", d1_rvalid, 1);
    chk("d1_rdata", d1_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1 d1_rready = 1;
    @(posedge clk); #1 d1_rready = 0;
    @(negedge clk);
    chk("d1_rvalid_clr", d1_rvalid, 0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
